// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
//   - segment patterns {g,f,e,d,c,b,a}, active-low
//   - digit slot indices (scan order)
//   - anode one-hot lookup
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIG_SCORE_ONES = 2'd0,
    DIG_SCORE_TENS = 2'd1,
    DIG_TIME_ONES  = 2'd2,
    DIG_TIME_TENS  = 2'd3
  } digit_e;

  // Active-high one-hot; the driver inverts for the common-anode pins.
  function automatic logic [3:0] anode_onehot(input digit_e d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit inputs and display pins of the scan driver.
//   score_ones/score_tens/time_ones/time_tens : BCD digits from upstream
//   flash                                     : 1 = blink whole display
//   an  : anode enables, active-low (an[0]=score_ones .. an[3]=time_tens)
//   seg : cathodes {g,f,e,d,c,b,a}, active-low
//   dp  : decimal point, active-low
// Modports: master = digit source / display observer, slave = driver.
interface seg7_scan_driver_if;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [3:0] time_ones;
  logic [3:0] time_tens;
  logic       flash;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output score_ones, score_tens, time_ones, time_tens, flash,
    input  an, seg, dp
  );

  modport slave (
    input  score_ones, score_tens, time_ones, time_tens, flash,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to seven-segment decoder.
//   bcd : 4-bit digit; 10..15 are invalid and show a dash
//   seg : {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode
// seven-segment display (score pair + remaining-time pair).
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : seg7_scan_driver_if.slave (digits, flash in; an/seg/dp out)
// Parameters:
//   REFRESH_BITS      : refresh counter width, top 2 bits select the digit
//   FLASH_FRAMES_LOG2 : flash phase toggles every 2^FLASH_FRAMES_LOG2 frames
// Build option: define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_BITS      = 18,
  parameter int unsigned FLASH_FRAMES_LOG2 = 7
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  logic [REFRESH_BITS-1:0]      cnt;
  logic [FLASH_FRAMES_LOG2-1:0] frame;
  logic                         phase;
  logic [3:0]                   snap [4];

  digit_e     idx;
  logic [3:0] digit;
  logic [6:0] seg_dec;
  logic [6:0] seg_next;
  logic       wrap;
  logic       dark;

  assign idx   = digit_e'(cnt[REFRESH_BITS-1 -: 2]);
  assign digit = snap[idx];
  assign wrap  = (cnt == '1);
  assign dark  = bus.flash && phase;

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (seg_dec)
  );

  always_comb begin
    seg_next = seg_dec;
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx == DIG_SCORE_TENS || idx == DIG_TIME_TENS) && digit == 4'd0)
      seg_next = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      frame  <= '0;
      phase  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) snap[i] <= '0;
      bus.an  <= '1;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      // Capture on the last cycle of a frame so the next frame is tear-free.
      if (wrap) begin
        frame   <= frame + 1'b1;
        snap[0] <= bus.score_ones;
        snap[1] <= bus.score_tens;
        snap[2] <= bus.time_ones;
        snap[3] <= bus.time_tens;
      end
      if (!bus.flash)
        phase <= 1'b0;
      else if (wrap && frame == '1)
        phase <= ~phase;

      bus.seg <= seg_next;
      bus.an  <= dark ? 4'b1111 : ~anode_onehot(idx);
      bus.dp  <= dark ? 1'b1 : (idx != DIG_TIME_ONES);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int RB = 4;
  localparam int FL = 1;
  localparam int FRAME = 1 << RB;
  localparam int SLOT  = FRAME / 4;
  localparam int FLASH_FRAMES = 1 << FL;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.REFRESH_BITS(RB), .FLASH_FRAMES_LOG2(FL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t  sb [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_tag  = "reset";

  // Reference model state: clocks since reset, per-frame captured digits, flash phase.
  int         edges = 0;
  logic [3:0] shown [4];
  bit         m_phase = 0;

  logic [6:0] pat [10];
  initial begin
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
    pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
    pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
    pat[9] = 7'b0010000;
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] v, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    if ((slot == 1 || slot == 3) && v == 0) return 7'b1111111;
`endif
    if (v > 9) return 7'b0111111;
    return pat[v];
  endfunction

  // Model: predicts what the display shows after each clock edge.
  initial begin
    for (int i = 0; i < 4; i++) shown[i] = 4'd0;
    forever begin
      @(posedge clk);
      begin
        exp_t e;
        e.tag = cur_tag;
        if (rst) begin
          e.an = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1;
          edges = 0;
          m_phase = 0;
          for (int i = 0; i < 4; i++) shown[i] = 4'd0;
        end else begin
          int pos, slot, fr;
          bit off;
          pos  = edges % FRAME;
          fr   = edges / FRAME;
          slot = pos / SLOT;
          off  = bus.flash && m_phase;
          e.an  = off ? 4'b1111 : ~(4'b0001 << slot);
          e.dp  = off ? 1'b1 : (slot != 2);
          e.seg = ref_seg(shown[slot], slot);
          if (pos == FRAME - 1) begin
            shown[0] = bus.score_ones; shown[1] = bus.score_tens;
            shown[2] = bus.time_ones;  shown[3] = bus.time_tens;
          end
          if (!bus.flash) m_phase = 0;
          else if (pos == FRAME - 1 && (fr % FLASH_FRAMES) == FLASH_FRAMES - 1)
            m_phase = !m_phase;
          edges++;
        end
        sb.push_back(e);
      end
    end
  end

  // Monitor: compares each presented output against the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (bus.an !== e.an) begin
          n_fail++;
          $display("FAIL %s an: got %b expected %b at %0t", e.tag, bus.an, e.an, $time);
        end
        n_checks++;
        if (bus.seg !== e.seg) begin
          n_fail++;
          $display("FAIL %s seg: got %b expected %b at %0t", e.tag, bus.seg, e.seg, $time);
        end
        n_checks++;
        if (bus.dp !== e.dp) begin
          n_fail++;
          $display("FAIL %s dp: got %b expected %b at %0t", e.tag, bus.dp, e.dp, $time);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_digits(input logic [3:0] so, st, to, tt);
    bus.score_ones = so; bus.score_tens = st;
    bus.time_ones  = to; bus.time_tens  = tt;
  endtask

  // Waits (bounded) until the DUT counter, as tracked by the model, equals pos.
  task automatic wait_pos(input int pos, input string what);
    int budget = 4 * FRAME;
    while ((rst || (edges % FRAME) != pos) && budget > 0) begin
      tick(1);
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL %s wait: got timeout expected counter=%0d", what, pos);
    end
  endtask

  initial begin
    set_digits(0, 0, 0, 0);
    bus.flash = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    cur_tag = "zeros";
    tick(2 * FRAME);

    cur_tag = "score42_time59";
    set_digits(4, 2, 9, 5);
    tick(3 * FRAME);

    cur_tag = "tear_free";
    set_digits(3, 2, 9, 5);
    tick(2 * FRAME);
    wait_pos(6, "tear_free");
    bus.score_ones = 4'd7;
    tick(2 * FRAME);

    cur_tag = "invalid_dash";
    bus.score_ones = 4'hC;
    bus.time_tens  = 4'hF;
    tick(2 * FRAME);

    cur_tag = "zero_tens";
    set_digits(5, 0, 1, 0);
    tick(2 * FRAME);

    cur_tag = "flash";
    set_digits(8, 8, 8, 8);
    bus.flash = 1'b1;
    tick(9 * FRAME);
    begin
      int budget = 8 * FRAME;
      while (!(m_phase && (edges % FRAME) == 5) && budget > 0) begin
        tick(1);
        budget--;
      end
      n_checks++;
      if (budget == 0) begin
        n_fail++;
        $display("FAIL flash_off wait: got timeout expected off phase");
      end
    end
    cur_tag = "flash_drop";
    bus.flash = 1'b0;
    tick(2 * FRAME);

    cur_tag = "reset_mid";
    wait_pos(9, "reset_mid");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2 * FRAME);

    cur_tag = "random";
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15)));
      if ($urandom_range(0, 63) == 0) bus.flash = ~bus.flash;
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(FRAME);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the 4-digit common-anode seven-segment display on Basys 3.
- Sits directly downstream of the binary-to-BCD converters and consumes their `ones`/`tens` digit pairs:
  - one pair for the score;
  - one pair for the remaining game time.
- Per digit slot: captures the BCD digits once per frame, decodes them to segment patterns and drives the anodes.
- Supports blanking of invalid digits and a game-over flash.

Parameters:
- REFRESH_BITS, 18: width of the free-running refresh counter. Top 2 bits select the digit. Full frame = 2^REFRESH_BITS clk cycles, which is about 381 Hz at 100 MHz.
- FLASH_FRAMES_LOG2, 7: the flash phase toggles every 2^FLASH_FRAMES_LOG2 frames.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active-high
- score_ones  in  4  BCD ones digit of the score
- score_tens  in  4  BCD tens digit of the score
- time_ones  in  4  BCD ones digit of the remaining time
- time_tens  in  4  BCD tens digit of the remaining time
- flash  in  1  1 = blink the whole display (game over)
- an  out  4  anode enables, active-low; an[0]=score_ones, an[1]=score_tens, an[2]=time_ones, an[3]=time_tens
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; low only while an[2] is active (separator)

Behaviour:
- Clock and reset: one clock domain `clk`. `rst` is synchronous and active-high. No other reset source.
- Reset values:
  - refresh counter = 0, frame counter = 0, flash phase = 0;
  - digit snapshot = 0 for all 4 digits;
  - an = 4'b1111, seg = 7'h7F, dp = 1.
- Refresh counter:
  - increments every clk and wraps 2^REFRESH_BITS−1 → 0;
  - digit index = counter[REFRESH_BITS-1 : REFRESH_BITS-2], selecting 0, 1, 2, 3 in that order.
- Snapshot:
  - all four input digits are captured in the cycle the counter wraps to 0;
  - this makes the frame tear-free, because inputs changing mid-frame do not appear until the next frame.
- Output latency and timing:
  - an, seg and dp are registered;
  - they reflect the digit index and snapshot of the previous cycle, so latency is 1 clk;
  - exactly one an bit is low at any time outside reset and outside the flash-off phase.
- Decode (per slot):
  - values 0..9 map to the standard patterns, e.g. 0 → 7'b1000000 and 8 → 7'b0000000;
  - values 10..15 are invalid and display a dash, seg = 7'b0111111 (g only lit).
- Flash:
  - frame counter increments on each counter wrap;
  - flash phase toggles when the frame counter wraps.
  - While flash=1 and phase=1: an = 4'b1111 and dp = 1. The counters keep running.
  - While flash=0: phase is forced to 0, so the display turns on immediately when flash deasserts.
- Reset mid-frame: all state returns to reset values on the next clk edge. The first digit shown after reset is slot 0 with snapshot 0.
- Simultaneous input change and counter wrap: the new input value is captured.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN
- Defined:
  - if the snapshot tens digit of a pair is 0, its slot shows blank (seg = 7'h7F);
  - the anode is still scanned, to keep the duty cycle uniform;
  - applies independently to score_tens and time_tens.
- Undefined: a zero tens digit displays "0".

Decomposition:
- Package seg7_pkg:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - digit index constants DIG_SCORE_ONES..DIG_TIME_TENS;
  - anode one-hot lookup.
- Sub-module bcd_to_seg7: purely combinational 4-bit → 7-bit decoder with the invalid → dash rule. It is instantiated once, fed by the muxed snapshot digit.

Test Plan (REFRESH_BITS=4, FLASH_FRAMES_LOG2=1):
- Reset, then release with all inputs 0 → an walks 1110, 1101, 1011, 0111, each for 4 clks; seg = 1000000 throughout; dp low only during an=1011.
- Score 4/2, time 9/5 held → slot patterns per frame: an0 → "4" 0011001, an1 → "2" 0100100, an2 → "9" 0010000, an3 → "5" 0010010.
- score_ones changes from 3 to 7 at counter=6 → current frame still shows "3"; "7" appears only after the next wrap.
- score_ones = 4'hC → slot 0 shows seg = 0111111.
- flash=1 → display alternates 2 frames on and 2 frames off (an = 1111); flash drops during the off phase → next clk resumes scanning.
- With LEADING_ZERO_BLANK_EN, score 0/5 → slot 1 shows seg = 1111111 while an1 = 0. Without the macro, slot 1 shows 1000000.
- rst asserted at counter=9 → next clk an = 1111 and seg = 7F; after release the scan restarts at slot 0.
